// File: rtl/reset_sequencer.sv
// reset_sequencer: staggered release of per-sub-block resets after chip reset,
// with soft-reset arbitration and global resequence in normal operation.
module reset_sequencer #(
  parameter int NUM_OUT        = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int SOFT_CYCLES    = 8,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               global_req,
  input  logic [NUM_OUT-1:0] soft_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready,
  output logic               soft_ack
);

  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [2:0] S_RESET   = 3'd0;
  localparam logic [2:0] S_HOLD    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_SOFT    = 3'd4;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST =
    CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST =
    CNT_W'(SOFT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_OUT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE =
    IDX_W'(1);

  logic [1:0]         sync_q;
  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] pend_q, pend_d;
  logic [NUM_OUT-1:0] mask_q, mask_d;
  logic [NUM_OUT-1:0] rst_q, rst_d;
  logic               ready_q, ready_d;
  logic               ack_q, ack_d;
  logic [NUM_OUT-1:0] req_m;

  // Two-flop synchroniser for rst_n deassertion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign req_m = soft_req | pend_q;

  // Next-state decode; global_req outranks soft requests
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    mask_d  = mask_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    ack_d   = 1'b0;
    unique case (1'b1)
      (state_q == S_RESET): begin
        if (sync_q[1]) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      (state_q == S_HOLD): begin
        if (global_req) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
          pend_d  = '0;
        end else if (cnt_q == HOLD_LAST) begin
          rst_d[0] = 1'b0;
          cnt_d    = '0;
          if (NUM_OUT == 1) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = S_RELEASE;
            idx_d   = IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      (state_q == S_RELEASE): begin
        if (global_req) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
          pend_d  = '0;
        end else if (cnt_q == STAG_LAST) begin
          rst_d[idx_q] = 1'b0;
          cnt_d        = '0;
          idx_d        = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      (state_q == S_RUN): begin
        if (global_req) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
          pend_d  = '0;
        end else if (|req_m) begin
          rst_d   = rst_q | req_m;
          mask_d  = req_m;
          pend_d  = '0;
          ready_d = 1'b0;
          cnt_d   = '0;
          state_d = S_SOFT;
        end
      end
      (state_q == S_SOFT): begin
        if (global_req) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
          pend_d  = '0;
        end else begin
          pend_d = pend_q | soft_req;
          if (cnt_q == SOFT_LAST) begin
            rst_d   = rst_q & ~mask_q;
            ready_d = 1'b1;
            ack_d   = 1'b1;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
        idx_d   = '0;
        pend_d  = '0;
        rst_d   = '1;
        ready_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  assign rst_out  = rst_q;
  assign ready    = ready_q;
  assign soft_ack = ack_q;

endmodule
